// File: rtl/nibble_add_sequencer.sv
// Serial wide add/subtract over a shared external 4-bit ripple adder: one nibble per
// clock, least-significant first, with valid/ready handshakes on operands and result.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  input  logic                 in_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    nib_a_s, nib_b_s;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a_s = 4'b0000;
    nib_b_s = 4'b0000;
    for (int n = 0; n < NIBBLES; n++) begin
      nib_a_s = (idx_q == IW'(n)) ? a_q[4*n +: 4] : nib_a_s;
      nib_b_s = (idx_q == IW'(n)) ? b_q[4*n +: 4] : nib_b_s;
    end
  end

  // The external adder sees zeros outside RUN so it never toggles while idle.
  assign add_a   = (state_q == S_RUN) ? nib_a_s : 4'b0000;
  assign add_b   = (state_q == S_RUN) ? nib_b_s : 4'b0000;
  assign add_cin = (state_q == S_RUN) ? carry_q : 1'b0;

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && ready_q) begin
          // Subtraction is A + ~B + 1, so the caller's carry-in is dropped.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          sum_d[4*n +: 4] = (idx_q == IW'(n)) ? add_sum : sum_q[4*n +: 4];
        end
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign valid_d = (state_d == S_DONE);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer (NIBBLES=4) with an ideal 4-bit adder
// and an arithmetic reference model of the wide add/subtract result.
module tb_nibble_add_sequencer;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_cin, in_sub;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  nibble_add_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    int ua, ub, sa, sb, ru, rs;
    logic c, o;
    logic [15:0] s;
    ua = int'({16'h0000, a});
    ub = int'({16'h0000, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ru = ua - ub;
      rs = sa - sb;
      c  = (ua >= ub);
    end else begin
      ru = ua + ub + int'({31'd0, cin});
      rs = sa + sb + int'({31'd0, cin});
      c  = (ru > 65535);
    end
    s = ru[15:0];
    o = (rs > 32767) || (rs < -32768);
    return {o, c, s};
  endfunction

  // Drives one transaction with out_ready high; reports result, latency and adder traffic.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output logic [15:0] s, output logic c,
                        output logic o, output int lat, output logic [15:0] seq_a,
                        output logic [15:0] seq_b, output logic [3:0] seq_cin,
                        output logic rdy_in_run);
    bit got;
    got = 1'b0;
    lat = -1;
    seq_a = 16'h0000; seq_b = 16'h0000; seq_cin = 4'b0000; rdy_in_run = 1'b0;
    s = 16'h0000; c = 1'b0; o = 1'b0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (k < 4) begin
        seq_a[4*k +: 4] = add_a;
        seq_b[4*k +: 4] = add_b;
        seq_cin[k]      = add_cin;
      end
      rdy_in_run = rdy_in_run | in_ready;
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: out_valid stayed %b, required 1", out_valid);
      return;
    end
    s = out_sum; c = out_cout; o = out_ovf;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h c=%b o=%b, required all 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf);
    end
    n_checks++;
    if ({add_a, add_b, add_cin} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_adder: got a=%h b=%h cin=%b, required 0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic_add();
    logic [15:0] s, qa, qb; logic c, o, r; logic [3:0] qc; int lat;
    do_txn(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b0, 1'b0, 16'h5555}) begin
      n_fail++;
      $display("FAIL basic_result: got sum=%h c=%b o=%b, required 5555/0/0", s, c, o);
    end
    n_checks++;
    if (qa !== 16'h1234 || qb !== 16'h4321) begin
      n_fail++;
      $display("FAIL basic_nibble_order: got a=%h b=%h, required 1234/4321 (lsn first)", qa, qb);
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, required 4", lat);
    end
    n_checks++;
    if (r !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_in_run: got %b, required 0", r);
    end
  endtask

  task automatic test_ripple();
    logic [15:0] s, qa, qb; logic c, o, r; logic [3:0] qc; int lat;
    do_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if (qc !== 4'b1110) begin
      n_fail++;
      $display("FAIL ripple_cin_seq: got %b, required 1110 (cycle0 in bit0)", qc);
    end
    n_checks++;
    if ({o, c, s} !== {1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL ripple_result: got sum=%h c=%b o=%b, required 0000/1/0", s, c, o);
    end
  endtask

  task automatic test_overflow_cin();
    logic [15:0] s, qa, qb; logic c, o, r; logic [3:0] qc; int lat;
    do_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b1, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL ovf_add: got sum=%h c=%b o=%b, required 8000/0/1", s, c, o);
    end
    do_txn(16'h0000, 16'h0000, 1'b1, 1'b0, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b0, 1'b0, 16'h0001}) begin
      n_fail++;
      $display("FAIL carry_in: got sum=%h c=%b o=%b, required 0001/0/0", s, c, o);
    end
  endtask

  task automatic test_subtract();
    logic [15:0] s, qa, qb; logic c, o, r; logic [3:0] qc; int lat;
    do_txn(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b0, 1'b0, 16'hFFFE}) begin
      n_fail++;
      $display("FAIL sub_borrow: got sum=%h c=%b o=%b, required FFFE/0/0", s, c, o);
    end
    do_txn(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b1, 1'b1, 16'h7FFF}) begin
      n_fail++;
      $display("FAIL sub_ovf: got sum=%h c=%b o=%b, required 7FFF/1/1", s, c, o);
    end
  endtask

  task automatic test_random();
    logic [15:0] s, qa, qb, a, b; logic c, o, r, cin, sub; logic [3:0] qc; int lat;
    logic [17:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      exp = model(a, b, cin, sub);
      do_txn(a, b, cin, sub, s, c, o, lat, qa, qb, qc, r);
      n_checks++;
      if ({o, c, s} !== exp || lat !== 4) begin
        n_fail++;
        $display("FAIL random_result %0d: a=%h b=%h cin=%b sub=%b got %h/%b/%b lat %0d, required %h/%b/%b lat 4",
                 i, a, b, cin, sub, s, c, o, lat, exp[15:0], exp[16], exp[17]);
      end
      n_checks++;
      if (qa !== a || qb !== (sub ? ~b : b)) begin
        n_fail++;
        $display("FAIL random_adder_ops %0d: got a=%h b=%h, required a=%h b=%h",
                 i, qa, qb, a, sub ? ~b : b);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp1, exp2;
    logic [15:0] a2, b2;
    bit seen;
    a2 = 16'hA5C3; b2 = 16'h1111;
    exp1 = model(16'h2468, 16'h1357, 1'b0, 1'b0);
    exp2 = model(a2, b2, 1'b0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 16'h2468; in_b = 16'h1357; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen || {out_ovf, out_cout, out_sum} !== exp1) begin
      n_fail++;
      $display("FAIL bp_result: got vld=%b %h/%b/%b, required 1 %h/%b/%b", out_valid,
               out_sum, out_cout, out_ovf, exp1[15:0], exp1[16], exp1[17]);
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out_ovf, out_cout, out_sum} !== {1'b1, 1'b0, exp1}) begin
        n_fail++;
        $display("FAIL bp_hold %0d: got vld=%b rdy=%b %h/%b/%b, required 1 0 %h/%b/%b", k,
                 out_valid, in_ready, out_sum, out_cout, out_ovf, exp1[15:0], exp1[16], exp1[17]);
      end
    end
    in_a = a2; in_b = b2; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, add_a} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL bp_release_idle: got rdy=%b vld=%b add_a=%h, required 1 0 0",
               in_ready, out_valid, add_a);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, add_a} !== {1'b0, a2[3:0]}) begin
      n_fail++;
      $display("FAIL bp_new_accept: got rdy=%b add_a=%h, required 0 %h", in_ready, add_a, a2[3:0]);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen || {out_ovf, out_cout, out_sum} !== exp2) begin
      n_fail++;
      $display("FAIL bp_second_result: got vld=%b %h/%b/%b, required 1 %h/%b/%b", out_valid,
               out_sum, out_cout, out_ovf, exp2[15:0], exp2[16], exp2[17]);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s, qa, qb; logic c, o, r; logic [3:0] qc; int lat;
    bit seen;
    @(negedge clk);
    out_ready = 1'b1;
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin} !== 28'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got rdy=%b vld=%b sum=%h c=%b o=%b a=%h b=%h cin=%b, required 0",
               in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_valid: got out_valid pulse %b, required 0", seen);
    end
    do_txn(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, o, lat, qa, qb, qc, r);
    n_checks++;
    if ({o, c, s} !== {1'b0, 1'b0, 16'h0100}) begin
      n_fail++;
      $display("FAIL midrst_next_txn: got sum=%h c=%b o=%b, required 0100/0/0", s, c, o);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_ripple();
    test_overflow_cin();
    test_subtract();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
